// File: rtl/adder_seq_ctrl.sv
// Byte-serial multi-precision adder: streams two NUM_BYTES-wide operands LSB-first through one 8-bit adder.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_MODE_EN.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       overflow
);

  assign {overflow, sum} = 9'(a) + 9'(b) + 9'(carry_in);

endmodule

module adder_seq_ctrl #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
`ifdef ADDER_SEQ_SUB_MODE_EN
  input  logic                   sub,
`endif
  input  logic [8*NUM_BYTES-1:0] op_a,
  input  logic [8*NUM_BYTES-1:0] op_b,
  input  logic                   carry_in,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   carry_out
);

  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned CNT_W = $clog2(NUM_BYTES);
  localparam int unsigned LAST  = NUM_BYTES - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  logic [W-1:0]       a_shift;
  logic [W-1:0]       b_shift;
  logic [W-1:0]       sum_shift;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt;

  logic               accept_c;
  logic               last_byte_c;
  logic [7:0]         b_byte_c;
  logic [7:0]         sum_c;
  logic               ovf_c;
  logic [W-1:0]       sum_shift_c;

`ifdef ADDER_SEQ_SUB_MODE_EN
  logic               sub_reg;
  assign b_byte_c = b_shift[7:0] ^ {8{sub_reg}};
`else
  assign b_byte_c = b_shift[7:0];
`endif

  assign accept_c    = (state == ST_IDLE) && start;
  assign last_byte_c = (state == ST_ADD) && (cnt == CNT_W'(LAST));
  assign sum_shift_c = {sum_c, sum_shift[W-1:8]};

  adder_8bit u_adder (
    .a        (a_shift[7:0]),
    .b        (b_byte_c),
    .carry_in (carry_reg),
    .sum      (sum_c),
    .overflow (ovf_c)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start)       state_nxt = ST_ADD;
      ST_ADD:  if (last_byte_c) state_nxt = ST_DONE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode, registered below so busy/done align with the state they describe
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    unique case (state_nxt)
      ST_ADD:  busy_nxt = 1'b1;
      ST_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Byte-serial datapath: operands shift out LSB-first, sums shift in from the top
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_shift   <= '0;
      b_shift   <= '0;
      sum_shift <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef ADDER_SEQ_SUB_MODE_EN
      sub_reg   <= 1'b0;
`endif
    end else if (accept_c) begin
      a_shift   <= op_a;
      b_shift   <= op_b;
      cnt       <= '0;
`ifdef ADDER_SEQ_SUB_MODE_EN
      sub_reg   <= sub;
      carry_reg <= sub | carry_in;
`else
      carry_reg <= carry_in;
`endif
    end else if (state == ST_ADD) begin
      a_shift   <= a_shift >> 8;
      b_shift   <= b_shift >> 8;
      sum_shift <= sum_shift_c;
      carry_reg <= ovf_c;
      cnt       <= cnt + CNT_W'(1);
      if (last_byte_c) begin
        result    <= sum_shift_c;
        carry_out <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NUM_BYTES=4); exercises subtract mode when ADDER_SEQ_SUB_MODE_EN is defined.

module tb_adder_seq_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         carry_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef ADDER_SEQ_SUB_MODE_EN
  logic         sub;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
`ifdef ADDER_SEQ_SUB_MODE_EN
    .sub       (sub),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, carry_out is bit W of the wide sum
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    return r;
  endfunction

  // One full transaction starting from IDLE; checks busy window, done pulse and result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input string tag);
    logic [W:0] exp;
    exp = model(a, b, c, s);
    @(negedge clk);
    check({tag, " idle_done"}, 64'(done), 64'(0));
    check({tag, " idle_busy"}, 64'(busy), 64'(0));
    op_a = a; op_b = b; carry_in = c; start = 1'b1;
`ifdef ADDER_SEQ_SUB_MODE_EN
    sub = s;
`endif
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; carry_in = 1'($urandom);
`ifdef ADDER_SEQ_SUB_MODE_EN
    sub = 1'($urandom);
`endif
    for (int k = 1; k <= int'(NB); k++) begin
      if (k > 1) @(negedge clk);
      check({tag, " busy"}, 64'(busy), 64'(1));
      check({tag, " no_done"}, 64'(done), 64'(0));
    end
    @(negedge clk);
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " busy_off"}, 64'(busy), 64'(0));
    check({tag, " result"}, 64'(result), 64'(exp[W-1:0]));
    check({tag, " carry_out"}, 64'(carry_out), 64'(exp[W]));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    n_rst = 1'b0; start = 1'b0; carry_in = 1'b0; op_a = '0; op_b = '0;
`ifdef ADDER_SEQ_SUB_MODE_EN
    sub = 1'b0;
`endif

    // Reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      op_a = 32'hDEADBEEF; op_b = 32'h01020304;
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst result", 64'(result), 64'(0));
      check("rst carry_out", 64'(carry_out), 64'(0));
    end
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "byte_carry");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "full_ripple");

    // Start during ADD and DONE is dropped
    @(negedge clk);
    op_a = 32'h12345678; op_b = 32'h11111111; carry_in = 1'b0; start = 1'b1;
`ifdef ADDER_SEQ_SUB_MODE_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    check("ign c1 busy", 64'(busy), 64'(1));
    @(negedge clk);
    op_a = 32'hFFFFFFFF; start = 1'b1;
    check("ign c2 busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("ign c3 busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("ign c4 busy", 64'(busy), 64'(1));
    check("ign c4 done", 64'(done), 64'(0));
    @(negedge clk);
    check("ign c5 done", 64'(done), 64'(1));
    check("ign result", 64'(result), 64'(32'h23456789));
    check("ign carry_out", 64'(carry_out), 64'(0));
    @(negedge clk);
    start = 1'b0;
    check("ign c6 done", 64'(done), 64'(0));
    check("ign c6 busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("ign c7 busy", 64'(busy), 64'(0));
    check("ign c7 done", 64'(done), 64'(0));
    check("ign c7 result", 64'(result), 64'(32'h23456789));

    // Reset in the middle of an add
    @(negedge clk);
    op_a = 32'hAAAA0000; op_b = 32'h5555FFFF; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst result", 64'(result), 64'(0));
    check("midrst carry_out", 64'(carry_out), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, "post_rst");

`ifdef ADDER_SEQ_SUB_MODE_EN
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, "sub5m7");
    check("sub5m7 abs_result", 64'(result), 64'(32'hFFFFFFFE));
    check("sub5m7 abs_borrow", 64'(carry_out), 64'(0));
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b0, "add5p7");
    check("add5p7 abs_result", 64'(result), 64'(32'h0000000C));
`endif

    // Randomized back-to-back operations at minimum spacing
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef ADDER_SEQ_SUB_MODE_EN
      rs = 1'($urandom);
`endif
      if (i % 6 == 1) ra = 32'hFFFFFFFF;
      if (i % 6 == 2) rb = ~ra;
      run_op(ra, rb, rc, rs, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

- Byte-serial multi-precision adder controller.
- Accepts two NUM_BYTES-wide operands and one carry-in through a start/busy/done handshake.
- Sequences them through one shared adder_8bit instance, least-significant byte first, chaining the carry between bytes.
- Sits between the control logic and the 8-bit adder datapath, so wide sums need no wide carry chain.

## Interface
Parameters:
- NUM_BYTES, 4, operand width in bytes; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  subtract request; port exists only when SUB_MODE_EN is defined.
- op_a  input  8*NUM_BYTES  operand A; latched on accepted start.
- op_b  input  8*NUM_BYTES  operand B; latched on accepted start.
- carry_in  input  1  initial carry; latched on accepted start.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse; result and carry_out are valid from this cycle.
- result  output  8*NUM_BYTES  last completed sum; held until the next completion.
- carry_out  output  1  carry out of the most-significant byte of the last completed operation.

## Operation
- Internal instance: adder_8bit.
  - a = a_shift[7:0].
  - b = b_shift[7:0].
  - carry_in = carry_reg.
  - Outputs used: sum[7:0] and overflow (carry out of bit 7).
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 latches op_a into a_shift, op_b into b_shift, carry_in into carry_reg.
  - Byte counter cleared to 0; next state ADD.
  - start=0 stays in IDLE.
- ADD, each cycle:
  - a_shift and b_shift shift right by 8.
  - Adder sum enters sum_shift at the top byte; sum_shift shifts right by 8.
  - carry_reg <= overflow; counter increments.
  - When the counter reaches NUM_BYTES-1: result <= final sum_shift, carry_out <= overflow, next state DONE.
- DONE:
  - done=1 for exactly one cycle; next state IDLE unconditionally.
- start outside IDLE is ignored, including in DONE. It is not queued.
- Operands are latched, so op_a/op_b/carry_in may change freely after the accepting edge.
- Width rule: result = (op_a + op_b + carry_in) mod 2^(8*NUM_BYTES); carry_out = bit 8*NUM_BYTES of that sum.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, result=0, carry_out=0.
  - Internal: state IDLE, all shift registers, carry_reg and counter = 0.
- Edge 0: start sampled high in IDLE.
- Edges 1..NUM_BYTES: one byte processed per edge; busy high during cycles 1..NUM_BYTES.
- Edge NUM_BYTES: result and carry_out update.
- done high during cycle NUM_BYTES+1; latency start-to-done is NUM_BYTES+1 cycles.
- Minimum spacing between accepted starts: NUM_BYTES+2 cycles.
- busy and done are never high together.
- n_rst low at any time, including mid-ADD:
  - All state returns to reset values immediately; the partial result is discarded.
  - The first start after deassertion is accepted normally.
- Carry ripple across all bytes (e.g. 0xFF..FF + 1) propagates through carry_reg, one byte per cycle, with no extra latency.

## Configuration
- Macro: ADDER_SEQ_SUB_MODE_EN.
- Defined:
  - sub port present and latched with start.
  - When sub=1: adder b = ~b_shift[7:0], initial carry_reg = 1 (carry_in ignored).
  - result = op_a - op_b mod 2^(8*NUM_BYTES); carry_out=1 means no borrow.
  - When sub=0: add behaviour unchanged.
- Undefined: no sub port; add only.

## Test plan
All scenarios use NUM_BYTES=4.
1. Reset: hold n_rst=0, toggle start -> busy=0, done=0, result=0x00000000, carry_out=0.
2. Byte carry: op_a=0x000000FF, op_b=0x00000001, carry_in=0, start at edge 0:
   - busy high cycles 1-4.
   - done high cycle 5 only.
   - result=0x00000100, carry_out=0.
3. Full ripple: op_a=0xFFFFFFFF, op_b=0x00000000, carry_in=1 -> result=0x00000000, carry_out=1.
4. Ignored start: op_a=0x12345678, op_b=0x11111111 accepted; second start with op_a=0xFFFFFFFF during cycle 2 -> result=0x23456789, single done pulse, second start dropped.
5. Mid-operation reset: n_rst low during cycle 2 of an add -> busy, done, result, carry_out all 0 immediately; a new add of 1+2 then gives result=0x00000003 with done on cycle 5.
6. ADDER_SEQ_SUB_MODE_EN defined: op_a=0x00000005, op_b=0x00000007, sub=1 -> result=0xFFFFFFFE, carry_out=0. Same operands with sub=0 -> result=0x0000000C.
